tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive end of the 4-lane 1-bit selector path: a time-division demultiplexer.
- The far side selects one of LANES input bits per slot onto a single data line and marks slot 0 with a frame-sync strobe.
- This block tracks slot position, deserializes each frame into a shadow register, and commits all lanes atomically to parallel outputs.
- It sits between the dedicated input pins and downstream logic that consumes per-lane bits.

Parameters:
- LANES, 4, number of slots per frame (power of two, 2..16).
- WIDTH, 1, bits carried per slot.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  slot strobe; slot logic advances only when high, everything holds when low.
- sync_in  input  1  frame marker, high during slot 0 only.
- data_in  input  WIDTH  slot payload.
- lane_out  output  LANES*WIDTH  committed frame; lane k occupies bits [k*WIDTH +: WIDTH].
- frame_vld  output  1  one-cycle pulse when lane_out updates.
- locked  output  1  high in LOCKED state.
- slot_idx  output  clog2(LANES)  next expected slot.
- err  output  1  one-cycle pulse on sync violation or (optional) parity failure.

Behaviour:
- Reset values (asynchronous): lane_out=0, frame_vld=0, locked=0, slot_idx=0, err=0, shadow=0, state=HUNT.
- Two states: HUNT and LOCKED. All transitions are qualified by en=1; en=0 freezes state, slot_idx, and shadow, and forces frame_vld=0 and err=0.
- HUNT:
  - sync_in=1: capture data_in into shadow[0], slot_idx=1, go to LOCKED.
  - Otherwise remain in HUNT and discard data.
- LOCKED, slot_idx=s:
  - s≠0 and sync_in=0: capture into shadow[s], then s+1.
  - s≠0 and sync_in=1 (early sync): err pulse, discard the partial frame, capture into shadow[0], slot_idx=1, stay in LOCKED.
  - s=0 and sync_in=1: normal frame start; capture into shadow[0], slot_idx=1.
  - s=0 and sync_in=0 (missed sync): err pulse, go to HUNT, slot_idx=0; lane_out keeps its last committed value.
- Commit rule:
  - On the capture of slot LANES-1, slot_idx wraps to 0.
  - The next edge loads lane_out from shadow with the final slot merged in, and frame_vld=1 for exactly one cycle.
  - Latency: lane_out is valid 1 cycle after the final slot's en cycle.
- lane_out never shows a partially updated frame.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
- Macro TDM_DEMUX_PARITY_EN.
- Defined:
  - The frame is LANES+1 slots long; the extra final slot carries even parity, i.e. the XOR of all frame payload bits equals data_in[0] of the parity slot.
  - Match: commit and pulse frame_vld.
  - Mismatch: no commit, err pulse, stay in LOCKED with slot_idx=0.
  - slot_idx width grows to hold the value LANES.
- Undefined: frames are LANES slots and no parity is checked.

Decomposition:
- Package tdm_pkg holds:
  - the default LANES and WIDTH;
  - the SLOT_W constant (clog2 of frame length, including the parity slot when enabled);
  - the state enum {HUNT, LOCKED}.
- One natural sub-module, tdm_slot_tracker. It owns the HUNT/LOCKED FSM, the slot counter, and sync checking, and emits capture_slot, capture_en, commit, and sync_err. The top level holds the shadow, lane_out, and the parity check.

Test Plan:
- Reset, then en=1 with sync on the first slot and payload 1,0,1,1 → locked=1 after the first edge; lane_out=4'b1101 and frame_vld pulses once, 1 cycle after slot 3.
- Back-to-back frames 1,0,1,1 then 0,1,1,0 → lane_out=4'b1101 then 4'b0110; frame_vld pulses exactly once per frame and lane_out is stable between pulses.
- en toggled low for 3 cycles mid-frame (after slot 1) → slot_idx holds at 2, no output change; the frame completes correctly once en returns.
- sync_in high at slot 2 → err pulse and the partial frame is discarded; the new frame 0,0,1,1 commits lane_out=4'b1100.
- sync_in low at an expected slot 0 → err pulse, locked=0, lane_out retains its previous value; relock on the next sync.
- With TDM_DEMUX_PARITY_EN: frame 1,0,1,1 with parity 1 → commit; same frame with parity 0 → err, no frame_vld, lane_out unchanged.
- rst asserted at slot 2 → all outputs read 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/tdm_demux4_pkg.sv
// tdm_pkg: shared constants and types for the tdm_demux4 receive path.
// Holds the default lane count and slot width, the slot counter width
// helper, and the HUNT/LOCKED state type.
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds one parity slot per frame).
package tdm_pkg;

  localparam int LANES_DEF = 4;
  localparam int WIDTH_DEF = 1;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int PAR_SLOTS = 1;
`else
  localparam int PAR_SLOTS = 0;
`endif

  // Slots per frame on the wire, including the parity slot when enabled.
  function automatic int frame_len(input int lanes);
    return lanes + PAR_SLOTS;
  endfunction

  // Slot counter width; must hold every slot index of a frame.
  function automatic int slot_w(input int lanes);
    return $clog2(lanes + PAR_SLOTS);
  endfunction

  localparam int SLOT_W = slot_w(LANES_DEF);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: pin-side bus of the TDM demultiplexer.
//   en, sync_in, data_in            : slot strobe, frame marker, slot payload
//   lane_out, frame_vld             : committed frame and its update pulse
//   locked, slot_idx, err           : tracker status
// Modports: master (far side / consumer), slave (the demultiplexer).
interface tdm_demux4_if #(
  parameter int LANES = tdm_pkg::LANES_DEF,
  parameter int WIDTH = tdm_pkg::WIDTH_DEF
);
  localparam int SW = tdm_pkg::slot_w(LANES);

  logic                   en;
  logic                   sync_in;
  logic [WIDTH-1:0]       data_in;
  logic [LANES*WIDTH-1:0] lane_out;
  logic                   frame_vld;
  logic                   locked;
  logic [SW-1:0]          slot_idx;
  logic                   err;

  modport master (
    output en, sync_in, data_in,
    input  lane_out, frame_vld, locked, slot_idx, err
  );

  modport slave (
    input  en, sync_in, data_in,
    output lane_out, frame_vld, locked, slot_idx, err
  );
endinterface

// File: rtl/tdm_demux4_slot_tracker.sv
// tdm_slot_tracker: HUNT/LOCKED frame tracker and slot counter.
//   clk, rst        : clock, async active-high reset
//   i_en, i_sync    : slot strobe, frame marker
//   o_locked        : high in LOCKED
//   o_slot_idx      : next expected slot
//   o_capture_en    : store the current payload at o_capture_slot
//   o_commit        : final slot of the frame is being captured
//   o_sync_err      : early or missed frame sync this cycle
// Frame length grows by one parity slot under TDM_DEMUX_PARITY_EN.
//
// state  | meaning
// HUNT   | waiting for sync_in to mark slot 0, payload discarded
// LOCKED | aligned to the frame, slot counter names the next slot
module tdm_slot_tracker
  import tdm_pkg::*;
#(
  parameter  int LANES = LANES_DEF,
  localparam int SW    = slot_w(LANES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_sync,
  output logic          o_locked,
  output logic [SW-1:0] o_slot_idx,
  output logic [SW-1:0] o_capture_slot,
  output logic          o_capture_en,
  output logic          o_commit,
  output logic          o_sync_err
);

  localparam logic [SW-1:0] LAST = SW'(frame_len(LANES) - 1);

  tdm_state_e    r_state, w_state_nxt;
  logic [SW-1:0] r_slot, w_slot_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_slot_nxt     = r_slot;
    o_capture_en   = 1'b0;
    o_capture_slot = r_slot;
    o_commit       = 1'b0;
    o_sync_err     = 1'b0;
    if (i_en) begin
      case (r_state)
        HUNT: begin
          if (i_sync) begin
            o_capture_en   = 1'b1;
            o_capture_slot = '0;
            w_slot_nxt     = SW'(1);
            w_state_nxt    = LOCKED;
          end
        end
        LOCKED: begin
          if (r_slot == '0) begin
            if (i_sync) begin
              o_capture_en = 1'b1;
              w_slot_nxt   = SW'(1);
            end else begin
              o_sync_err  = 1'b1;
              w_state_nxt = HUNT;
            end
          end else if (i_sync) begin
            // Early sync: restart the frame from slot 0.
            o_sync_err     = 1'b1;
            o_capture_en   = 1'b1;
            o_capture_slot = '0;
            w_slot_nxt     = SW'(1);
          end else begin
            o_capture_en = 1'b1;
            if (r_slot == LAST) begin
              o_commit   = 1'b1;
              w_slot_nxt = '0;
            end else begin
              w_slot_nxt = r_slot + SW'(1);
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  assign o_locked   = (r_state == LOCKED);
  assign o_slot_idx = r_slot;

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: TDM receive demultiplexer. Deserializes one frame of LANES
// slots into a shadow register and commits all lanes to lane_out at once.
//   clk, rst : clock, async active-high reset
//   bus      : tdm_demux4_if.slave (en, sync_in, data_in in;
//              lane_out, frame_vld, locked, slot_idx, err out)
// Macro TDM_DEMUX_PARITY_EN: frame carries an extra even-parity slot; a
// mismatch suppresses the commit and pulses err.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  tdm_demux4_if.slave     bus
);

  localparam int SW     = slot_w(LANES);
  localparam int LANE_W = $clog2(LANES);

  logic [SW-1:0]          w_cap_slot;
  logic [SW-1:0]          w_slot_idx;
  logic                   w_cap_en;
  logic                   w_commit;
  logic                   w_sync_err;
  logic                   w_locked;
  logic                   w_cap_data;
  logic [LANE_W-1:0]      w_lane_idx;
  logic [LANES*WIDTH-1:0] w_frame;
  logic [WIDTH-1:0]       r_shadow [LANES];
  logic [LANES*WIDTH-1:0] r_lane_out;
  logic                   r_frame_vld;
  logic                   r_err;

  tdm_slot_tracker #(.LANES(LANES)) u_tracker (
    .clk            (clk),
    .rst            (rst),
    .i_en           (bus.en),
    .i_sync         (bus.sync_in),
    .o_locked       (w_locked),
    .o_slot_idx     (w_slot_idx),
    .o_capture_slot (w_cap_slot),
    .o_capture_en   (w_cap_en),
    .o_commit       (w_commit),
    .o_sync_err     (w_sync_err)
  );

  assign w_lane_idx = w_cap_slot[LANE_W-1:0];

`ifdef TDM_DEMUX_PARITY_EN
  logic w_par_ok;
  // The parity slot is never stored; it is only compared.
  assign w_cap_data = w_cap_en && (w_cap_slot < SW'(LANES));
  assign w_par_ok   = ((^w_frame) == bus.data_in[0]);
`else
  assign w_cap_data = w_cap_en;
`endif

  // Shadow with the slot being captured this cycle merged in, so the last
  // data slot lands in lane_out on the same edge that captures it.
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < LANES; k++) begin
      w_frame[k*WIDTH +: WIDTH] = (w_cap_data && (w_lane_idx == LANE_W'(k))) ?
                                  bus.data_in : r_shadow[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane_out  <= '0;
      r_frame_vld <= 1'b0;
      r_err       <= 1'b0;
      for (int k = 0; k < LANES; k++) r_shadow[k] <= '0;
    end else begin
      r_frame_vld <= 1'b0;
      r_err       <= w_sync_err;
      if (w_cap_data) begin
        // Slot 0 starts a fresh frame, so leftovers of a broken one are cleared.
        for (int k = 0; k < LANES; k++) begin
          if (w_lane_idx == '0)
            r_shadow[k] <= (k == 0) ? bus.data_in : '0;
          else if (w_lane_idx == LANE_W'(k))
            r_shadow[k] <= bus.data_in;
        end
      end
      if (w_commit) begin
`ifdef TDM_DEMUX_PARITY_EN
        if (w_par_ok) begin
          r_lane_out  <= w_frame;
          r_frame_vld <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
`else
        r_lane_out  <= w_frame;
        r_frame_vld <= 1'b1;
`endif
      end
    end
  end

  assign bus.lane_out  = r_lane_out;
  assign bus.frame_vld = r_frame_vld;
  assign bus.err       = r_err;
  assign bus.locked    = w_locked;
  assign bus.slot_idx  = w_slot_idx;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus a randomized
// run compared against a queue-based frame model.
module tb_tdm_demux4;
  import tdm_pkg::*;

  localparam int LANES = 4;
  localparam int WIDTH = 1;
  localparam int FRAME = frame_len(LANES);
  localparam int SW    = slot_w(LANES);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux4_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  tdm_demux4 #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: payloads collected since the last slot 0.
  bit                     m_locked;
  logic [WIDTH-1:0]       m_q[$];
  logic [LANES*WIDTH-1:0] m_lane;
  bit                     m_vld;
  bit                     m_err;

  task automatic model_reset();
    m_locked = 1'b0;
    m_q.delete();
    m_lane = '0;
    m_vld  = 1'b0;
    m_err  = 1'b0;
  endtask

  function automatic int m_slot();
    return m_locked ? m_q.size() : 0;
  endfunction

  task automatic model_step(input bit en, input bit sync, input logic [WIDTH-1:0] d);
    logic [LANES*WIDTH-1:0] f;
    m_vld = 1'b0;
    m_err = 1'b0;
    if (!en) return;
    if (!m_locked) begin
      if (sync) begin
        m_q = {d};
        m_locked = 1'b1;
      end
    end else if (m_q.size() == 0) begin
      if (sync) m_q = {d};
      else begin
        m_err = 1'b1;
        m_locked = 1'b0;
      end
    end else if (sync) begin
      m_err = 1'b1;
      m_q = {d};
    end else begin
      m_q.push_back(d);
      if (m_q.size() == FRAME) begin
        f = '0;
        for (int k = 0; k < LANES; k++) f[k*WIDTH +: WIDTH] = m_q[k];
`ifdef TDM_DEMUX_PARITY_EN
        if ((^f) == m_q[LANES][0]) begin
          m_lane = f;
          m_vld  = 1'b1;
        end else m_err = 1'b1;
`else
        m_lane = f;
        m_vld  = 1'b1;
`endif
        m_q.delete();
      end
    end
  endtask

  // One slot: drive inputs just after an edge, clock, then settle past the edge.
  task automatic slot(input bit en, input bit sync, input logic [WIDTH-1:0] d);
    bus.en = en;
    bus.sync_in = sync;
    bus.data_in = d;
    @(posedge clk);
    model_step(en, sync, d);
    #1;
  endtask

  // Full well-formed frame (plus a correct parity slot when enabled).
  task automatic send_frame(input logic [LANES*WIDTH-1:0] f);
    for (int k = 0; k < LANES; k++) slot(1'b1, k == 0, f[k*WIDTH +: WIDTH]);
`ifdef TDM_DEMUX_PARITY_EN
    slot(1'b1, 1'b0, WIDTH'(^f));
`endif
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.sync_in = 1'b0; bus.data_in = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_total++; if (bus.lane_out !== 4'b0000) $display("FAIL reset_lane_out: got %b exp 0000", bus.lane_out); else n_pass++;
    n_total++; if (bus.frame_vld !== 1'b0) $display("FAIL reset_frame_vld: got %b exp 0", bus.frame_vld); else n_pass++;
    n_total++; if (bus.locked !== 1'b0) $display("FAIL reset_locked: got %b exp 0", bus.locked); else n_pass++;
    n_total++; if (bus.slot_idx !== SW'(0)) $display("FAIL reset_slot_idx: got %0d exp 0", bus.slot_idx); else n_pass++;
    n_total++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b exp 0", bus.err); else n_pass++;
  endtask

  task automatic test_single_frame();
    slot(1'b1, 1'b1, 1'b1);
    n_total++; if (bus.locked !== 1'b1) $display("FAIL single_locked: got %b exp 1", bus.locked); else n_pass++;
    n_total++; if (bus.slot_idx !== SW'(1)) $display("FAIL single_slot_idx: got %0d exp 1", bus.slot_idx); else n_pass++;
    slot(1'b1, 1'b0, 1'b0);
    slot(1'b1, 1'b0, 1'b1);
    n_total++; if (bus.frame_vld !== 1'b0) $display("FAIL single_early_vld: got %b exp 0", bus.frame_vld); else n_pass++;
    slot(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
    n_total++; if (bus.frame_vld !== 1'b0) $display("FAIL single_pre_parity_vld: got %b exp 0", bus.frame_vld); else n_pass++;
    slot(1'b1, 1'b0, 1'b1);
`endif
    n_total++; if (bus.frame_vld !== 1'b1) $display("FAIL single_vld: got %b exp 1", bus.frame_vld); else n_pass++;
    n_total++; if (bus.lane_out !== 4'b1101) $display("FAIL single_lane_out: got %b exp 1101", bus.lane_out); else n_pass++;
    n_total++; if (bus.slot_idx !== SW'(0)) $display("FAIL single_wrap: got %0d exp 0", bus.slot_idx); else n_pass++;
    slot(1'b0, 1'b0, 1'b0);
    n_total++; if (bus.frame_vld !== 1'b0) $display("FAIL single_vld_once: got %b exp 0", bus.frame_vld); else n_pass++;
    n_total++; if (bus.lane_out !== 4'b1101) $display("FAIL single_hold: got %b exp 1101", bus.lane_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] f2;
    f2 = 4'b0110;
    send_frame(4'b1101);
    n_total++; if (bus.frame_vld !== 1'b1) $display("FAIL b2b_vld1: got %b exp 1", bus.frame_vld); else n_pass++;
    for (int k = 0; k < FRAME; k++) begin
      if (k < LANES) slot(1'b1, k == 0, f2[k]);
      else slot(1'b1, 1'b0, ^f2);
      if (k < FRAME - 1) begin
        n_total++; if (bus.frame_vld !== 1'b0 || bus.lane_out !== 4'b1101)
          $display("FAIL b2b_stable: got vld=%b lane=%b exp vld=0 lane=1101", bus.frame_vld, bus.lane_out);
        else n_pass++;
      end
    end
    n_total++; if (bus.frame_vld !== 1'b1) $display("FAIL b2b_vld2: got %b exp 1", bus.frame_vld); else n_pass++;
    n_total++; if (bus.lane_out !== 4'b0110) $display("FAIL b2b_lane2: got %b exp 0110", bus.lane_out); else n_pass++;
  endtask

  task automatic test_en_stall();
    slot(1'b1, 1'b1, 1'b1);
    slot(1'b1, 1'b0, 1'b0);
    n_total++; if (bus.slot_idx !== SW'(2)) $display("FAIL stall_pre_idx: got %0d exp 2", bus.slot_idx); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      slot(1'b0, 1'b1, 1'b1);
      n_total++; if (bus.slot_idx !== SW'(2) || bus.lane_out !== 4'b0110 || bus.frame_vld !== 1'b0 || bus.err !== 1'b0)
        $display("FAIL stall_hold: got idx=%0d lane=%b vld=%b err=%b exp idx=2 lane=0110 vld=0 err=0",
                 bus.slot_idx, bus.lane_out, bus.frame_vld, bus.err);
      else n_pass++;
    end
    slot(1'b1, 1'b0, 1'b0);
    slot(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
    slot(1'b1, 1'b0, 1'b0);
`endif
    n_total++; if (bus.frame_vld !== 1'b1) $display("FAIL stall_vld: got %b exp 1", bus.frame_vld); else n_pass++;
    n_total++; if (bus.lane_out !== 4'b1001) $display("FAIL stall_lane: got %b exp 1001", bus.lane_out); else n_pass++;
  endtask

  task automatic test_early_sync();
    slot(1'b1, 1'b1, 1'b1);
    slot(1'b1, 1'b0, 1'b1);
    slot(1'b1, 1'b1, 1'b0);
    n_total++; if (bus.err !== 1'b1) $display("FAIL early_err: got %b exp 1", bus.err); else n_pass++;
    n_total++; if (bus.slot_idx !== SW'(1) || bus.locked !== 1'b1)
      $display("FAIL early_restart: got idx=%0d locked=%b exp idx=1 locked=1", bus.slot_idx, bus.locked);
    else n_pass++;
    slot(1'b1, 1'b0, 1'b0);
    n_total++; if (bus.err !== 1'b0) $display("FAIL early_err_pulse: got %b exp 0", bus.err); else n_pass++;
    slot(1'b1, 1'b0, 1'b1);
    slot(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
    slot(1'b1, 1'b0, 1'b0);
`endif
    n_total++; if (bus.frame_vld !== 1'b1) $display("FAIL early_vld: got %b exp 1", bus.frame_vld); else n_pass++;
    n_total++; if (bus.lane_out !== 4'b1100) $display("FAIL early_lane: got %b exp 1100", bus.lane_out); else n_pass++;
  endtask

  task automatic test_missed_sync();
    slot(1'b1, 1'b0, 1'b1);
    n_total++; if (bus.err !== 1'b1) $display("FAIL missed_err: got %b exp 1", bus.err); else n_pass++;
    n_total++; if (bus.locked !== 1'b0) $display("FAIL missed_locked: got %b exp 0", bus.locked); else n_pass++;
    n_total++; if (bus.lane_out !== 4'b1100) $display("FAIL missed_lane: got %b exp 1100", bus.lane_out); else n_pass++;
    slot(1'b1, 1'b0, 1'b1);
    n_total++; if (bus.err !== 1'b0 || bus.locked !== 1'b0 || bus.slot_idx !== SW'(0))
      $display("FAIL missed_hunt: got err=%b locked=%b idx=%0d exp 0 0 0", bus.err, bus.locked, bus.slot_idx);
    else n_pass++;
    send_frame(4'b0101);
    n_total++; if (bus.locked !== 1'b1 || bus.lane_out !== 4'b0101)
      $display("FAIL missed_relock: got locked=%b lane=%b exp locked=1 lane=0101", bus.locked, bus.lane_out);
    else n_pass++;
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    send_frame(4'b1101);
    n_total++; if (bus.frame_vld !== 1'b1 || bus.lane_out !== 4'b1101)
      $display("FAIL parity_good: got vld=%b lane=%b exp vld=1 lane=1101", bus.frame_vld, bus.lane_out);
    else n_pass++;
    slot(1'b1, 1'b1, 1'b0);
    slot(1'b1, 1'b0, 1'b0);
    slot(1'b1, 1'b0, 1'b1);
    slot(1'b1, 1'b0, 1'b1);
    slot(1'b1, 1'b0, 1'b1);
    n_total++; if (bus.err !== 1'b1 || bus.frame_vld !== 1'b0)
      $display("FAIL parity_bad: got err=%b vld=%b exp err=1 vld=0", bus.err, bus.frame_vld);
    else n_pass++;
    n_total++; if (bus.lane_out !== 4'b1101 || bus.locked !== 1'b1 || bus.slot_idx !== SW'(0))
      $display("FAIL parity_hold: got lane=%b locked=%b idx=%0d exp 1101 1 0", bus.lane_out, bus.locked, bus.slot_idx);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    bit en, sync;
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 800; i++) begin
      en   = ($urandom_range(0, 4) != 0);
      sync = (m_slot() == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      d    = WIDTH'($urandom);
      slot(en, sync, d);
      n_total++; if (bus.lane_out !== m_lane) $display("FAIL rand_lane_out @%0d: got %b exp %b", i, bus.lane_out, m_lane); else n_pass++;
      n_total++; if (bus.frame_vld !== m_vld) $display("FAIL rand_frame_vld @%0d: got %b exp %b", i, bus.frame_vld, m_vld); else n_pass++;
      n_total++; if (bus.err !== m_err) $display("FAIL rand_err @%0d: got %b exp %b", i, bus.err, m_err); else n_pass++;
      n_total++; if (bus.locked !== m_locked) $display("FAIL rand_locked @%0d: got %b exp %b", i, bus.locked, m_locked); else n_pass++;
      n_total++; if (bus.slot_idx !== SW'(m_slot())) $display("FAIL rand_slot_idx @%0d: got %0d exp %0d", i, bus.slot_idx, m_slot()); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    send_frame(4'b1111);
    slot(1'b1, 1'b1, 1'b1);
    slot(1'b1, 1'b0, 1'b1);
    n_total++; if (bus.slot_idx !== SW'(2) || bus.lane_out !== 4'b1111)
      $display("FAIL areset_setup: got idx=%0d lane=%b exp idx=2 lane=1111", bus.slot_idx, bus.lane_out);
    else n_pass++;
    rst = 1'b1;
    #2;
    n_total++; if (bus.lane_out !== 4'b0000 || bus.frame_vld !== 1'b0 || bus.locked !== 1'b0 ||
                   bus.slot_idx !== SW'(0) || bus.err !== 1'b0)
      $display("FAIL areset_outputs: got lane=%b vld=%b locked=%b idx=%0d err=%b exp all 0",
               bus.lane_out, bus.frame_vld, bus.locked, bus.slot_idx, bus.err);
    else n_pass++;
    model_reset();
    rst = 1'b0;
    slot(1'b1, 1'b0, 1'b1);
    n_total++; if (bus.locked !== 1'b0 || bus.lane_out !== 4'b0000)
      $display("FAIL areset_after: got locked=%b lane=%b exp 0 0000", bus.locked, bus.lane_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_en_stall();
    test_early_sync();
    test_missed_sync();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
